// File: rtl/hazard_stall_controller_pkg.sv
// rtl/hazard_stall_controller_pkg.sv - shared constants, FSM encodings and source-hit helper
package hazard_stall_controller_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [4:0] X0 = 5'd0;

  typedef enum logic {
    HSC_IDLE    = 1'b0,
    HSC_LOAD_EX = 1'b1
  } hsc_state_t;

  // True when either used decode source reads register r; x0 never hits.
  function automatic logic src_hit(
    input logic       rs1_used,
    input logic [4:0] rs1_index,
    input logic       rs2_used,
    input logic [4:0] rs2_index,
    input logic [4:0] r
  );
    return (r != X0) &&
           ((rs1_used && (rs1_index == r)) || (rs2_used && (rs2_index == r)));
  endfunction

endpackage

// File: rtl/hazard_stall_controller_scoreboard.sv
// rtl/hazard_stall_controller_scoreboard.sv - per-register busy bits and outstanding long-op counter
module hsc_scoreboard
  import hazard_stall_controller_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_valid,
  input  logic [4:0]             set_index,
  input  logic                   count_inc,
  input  logic                   clr_valid,
  input  logic [4:0]             clr_index,
  input  logic [2:0][4:0]        query_index,
  output logic [2:0]             query_busy,
  output logic [31:0]            busy_vector,
  output logic [COUNT_WIDTH-1:0] outstanding_count
);

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_OUTSTANDING);

  logic [31:0]            busy_q;
  logic [31:0]            busy_next;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   clr_hit;

  // A writeback only retires an op if it lands on a register that is actually busy.
  assign clr_hit = clr_valid && (clr_index != X0) && busy_q[clr_index];

  // Busy queries see this cycle's retiring writeback as already cleared.
  always_comb begin
    query_busy = '0;
    for (int i = 0; i < 3; i++) begin
      query_busy[i] = (query_index[i] != X0) && busy_q[query_index[i]] &&
                      !(clr_hit && (clr_index == query_index[i]));
    end
  end

  // Next busy bits: clear first so a same-register set wins; x0 stays clear.
  always_comb begin
    busy_next = busy_q;
    if (clr_hit) begin
      busy_next[clr_index] = 1'b0;
    end
    if (set_valid && (set_index != X0)) begin
      busy_next[set_index] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Counter moves only when exactly one of issue/retire happens, saturating both ends.
  always_comb begin
    count_next = count_q;
    if (count_inc && !clr_hit && (count_q != MAX_CNT)) begin
      count_next = count_q + COUNT_WIDTH'(1);
    end else if (!count_inc && clr_hit && (count_q != '0)) begin
      count_next = count_q - COUNT_WIDTH'(1);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_next;
      count_q <= count_next;
    end
  end

  assign busy_vector       = busy_q;
  assign outstanding_count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use/long-latency stall sequencing; PERF_STALL_COUNT_EN adds stall_cycles
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_long,
  input  logic                   issue_is_load,
  input  logic                   issue_writes,
  input  logic [4:0]             rs1_index,
  input  logic [4:0]             rs2_index,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic                   writeback_valid,
  input  logic [4:0]             writeback_index,
  output logic                   stall,
  output logic [31:0]            busy_vector,
  output logic [COUNT_WIDTH-1:0] outstanding_count
`ifdef PERF_STALL_COUNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_OUTSTANDING);

  hsc_state_t     state_q;
  hsc_state_t     state_next;
  logic [4:0]     load_rd_q;
  logic [4:0]     load_rd_next;
  logic [2:0]     query_busy;
  logic [2:0][4:0] query_index;
  logic           raw_busy;
  logic           load_use;
  logic           waw;
  logic           full;
  logic           accept;
  logic           load_accept;

  assign query_index = {issue_rd, rs2_index, rs1_index};

  hsc_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .COUNT_WIDTH     (COUNT_WIDTH)
  ) u_scoreboard (
    .clk               (clk),
    .reset             (reset),
    .set_valid         (accept && issue_long && issue_writes),
    .set_index         (issue_rd),
    .count_inc         (accept && issue_long),
    .clr_valid         (writeback_valid),
    .clr_index         (writeback_index),
    .query_index       (query_index),
    .query_busy        (query_busy),
    .busy_vector       (busy_vector),
    .outstanding_count (outstanding_count)
  );

  // Hazard terms, all resolved in the same cycle the instruction sits in decode.
  always_comb begin
    raw_busy = (rs1_used && query_busy[0]) || (rs2_used && query_busy[1]);
    waw      = issue_writes && query_busy[2];
    load_use = (state_q == HSC_LOAD_EX) &&
               src_hit(rs1_used, rs1_index, rs2_used, rs2_index, load_rd_q);
    full     = issue_long && (outstanding_count == MAX_CNT) && !writeback_valid;
    stall    = !reset && issue_valid && (raw_busy || waw || load_use || full);
  end

  assign accept      = issue_valid && !stall;
  assign load_accept = accept && issue_is_load && (issue_rd != X0);

  // A load spends exactly one cycle in execute; a stall there drains back to IDLE.
  always_comb begin
    state_next   = HSC_IDLE;
    load_rd_next = load_rd_q;
    if (load_accept) begin
      state_next   = HSC_LOAD_EX;
      load_rd_next = issue_rd;
    end
  end

  // FSM state and tracked load destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HSC_IDLE;
      load_rd_q <= X0;
    end else begin
      state_q   <= state_next;
      load_rd_q <= load_rd_next;
    end
  end

`ifdef PERF_STALL_COUNT_EN
  // Free-running count of stalled cycles, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_long;
  logic        issue_is_load;
  logic        issue_writes;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic        rs1_used;
  logic        rs2_used;
  logic        writeback_valid;
  logic [4:0]  writeback_index;
  logic        stall;
  logic [31:0] busy_vector;
  logic [3:0]  outstanding_count;
`ifdef PERF_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks;
  int n_fail;
  int exp_stall_cycles;

  hazard_stall_controller #(
    .MAX_OUTSTANDING (4),
    .COUNT_WIDTH     (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_rd          (issue_rd),
    .issue_long        (issue_long),
    .issue_is_load     (issue_is_load),
    .issue_writes      (issue_writes),
    .rs1_index         (rs1_index),
    .rs2_index         (rs2_index),
    .rs1_used          (rs1_used),
    .rs2_used          (rs2_used),
    .writeback_valid   (writeback_valid),
    .writeback_index   (writeback_index),
    .stall             (stall),
    .busy_vector       (busy_vector),
    .outstanding_count (outstanding_count)
`ifdef PERF_STALL_COUNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // valid, rd, long, load, writes, rs1, rs2, rs1_used, rs2_used, wb_valid, wb_index
  task automatic drv(input logic v, input logic [4:0] rd, input logic lng, input logic ld,
                     input logic wr, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic wbv, input logic [4:0] wbi);
    issue_valid     = v;
    issue_rd        = rd;
    issue_long      = lng;
    issue_is_load   = ld;
    issue_writes    = wr;
    rs1_index       = r1;
    rs2_index       = r2;
    rs1_used        = u1;
    rs2_used        = u2;
    writeback_valid = wbv;
    writeback_index = wbi;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs already driven; check the combinational stall, then advance one clock.
  task automatic cyc(input string tag, input logic exp_stall);
    #1;
    check(tag, 32'(stall), 32'(exp_stall));
    if (exp_stall) exp_stall_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag, input logic [31:0] exp_busy, input logic [3:0] exp_cnt);
    check({tag, "_busy"}, busy_vector, exp_busy);
    check({tag, "_count"}, 32'(outstanding_count), 32'(exp_cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_stall_cycles = 0;
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    regs("reset", 32'h0, 4'd0);
    cyc("reset_stall", 1'b0);

    // Load-use: load x5 then add x6,x5,x7.
    drv(1, 5, 0, 1, 1, 1, 2, 1, 0, 0, 0);  cyc("lu_load", 1'b0);
    drv(1, 6, 0, 0, 1, 5, 7, 1, 1, 0, 0);  cyc("lu_stall", 1'b1);
    cyc("lu_accept", 1'b0);
    idle(); cyc("lu_idle", 1'b0);

    // Back-to-back loads: second load retargets the tracked rd.
    drv(1, 5, 0, 1, 1, 1, 0, 1, 0, 0, 0);  cyc("ll_load5", 1'b0);
    drv(1, 7, 0, 1, 1, 2, 0, 1, 0, 0, 0);  cyc("ll_load7", 1'b0);
    drv(1, 9, 0, 0, 1, 5, 7, 1, 1, 0, 0);  cyc("ll_use7", 1'b1);
    cyc("ll_after", 1'b0);
    idle(); cyc("ll_idle", 1'b0);

    // Long RAW: div x3, dependant stalls until writeback x3 bypasses.
    drv(1, 3, 1, 0, 1, 1, 2, 1, 1, 0, 0);  cyc("raw_div", 1'b0);
    regs("raw_set", 32'h0000_0008, 4'd1);
    drv(0, 6, 0, 0, 1, 3, 0, 1, 0, 0, 0);  cyc("raw_novalid", 1'b0);
    drv(1, 6, 0, 0, 1, 4, 3, 1, 1, 0, 0);  cyc("raw_stall0", 1'b1);
    cyc("raw_stall1", 1'b1);
    drv(1, 6, 0, 0, 1, 4, 3, 1, 1, 1, 3);  cyc("raw_bypass", 1'b0);
    regs("raw_clr", 32'h0, 4'd0);
    idle(); cyc("raw_idle", 1'b0);

    // WAW with same-cycle set/clear on x8.
    drv(1, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0);  cyc("waw_mul0", 1'b0);
    regs("waw_set", 32'h0000_0100, 4'd1);
    drv(1, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0);  cyc("waw_stall", 1'b1);
    drv(1, 8, 1, 0, 1, 0, 0, 0, 0, 1, 8);  cyc("waw_setclr", 1'b0);
    regs("waw_setwins", 32'h0000_0100, 4'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);  cyc("waw_wb", 1'b0);
    regs("waw_done", 32'h0, 4'd0);

    // Full counter: four long ops fill the budget.
    for (int i = 1; i <= 4; i++) begin
      drv(1, 5'(i), 1, 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("full_fill", 1'b0);
    end
    regs("full_fill", 32'h0000_001E, 4'd4);
    drv(1, 10, 1, 0, 1, 0, 0, 0, 0, 0, 0); cyc("full_stall", 1'b1);
    regs("full_hold", 32'h0000_001E, 4'd4);
    drv(1, 10, 1, 0, 1, 0, 0, 0, 0, 1, 1); cyc("full_wb_accept", 1'b0);
    regs("full_swap", 32'h0000_041C, 4'd4);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);  cyc("full_d2", 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);  cyc("full_d3", 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);  cyc("full_d4", 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10); cyc("full_d10", 1'b0);
    regs("full_drain", 32'h0, 4'd0);

    // x0: long op to x0 sets no busy bit but still counts as in flight.
    drv(1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);  cyc("x0_long", 1'b0);
    regs("x0_long", 32'h0, 4'd1);
    drv(1, 9, 1, 0, 1, 0, 0, 1, 1, 0, 0);  cyc("x9_long", 1'b0);
    regs("x9_long", 32'h0000_0200, 4'd2);
    drv(1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0);  cyc("x0_src_wb", 1'b0);
    regs("x0_wb_ignored", 32'h0000_0200, 4'd2);

`ifdef PERF_STALL_COUNT_EN
    check("perf_count", stall_cycles, 32'(exp_stall_cycles));
`endif

    // Reset mid-operation with a dependant on busy x9 in decode.
    reset = 1'b1;
    drv(1, 6, 0, 0, 1, 9, 0, 1, 0, 0, 0);
    cyc("rst_stall_during", 1'b0);
    reset = 1'b0;
    regs("rst_cleared", 32'h0, 4'd0);
`ifdef PERF_STALL_COUNT_EN
    check("perf_reset", stall_cycles, 32'h0);
`endif
    cyc("rst_stall_after", 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);  cyc("rst_late_wb", 1'b0);
    regs("rst_late_wb", 32'h0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
